// File: rtl/test_wr_pkg.sv
// Shared types and default parameter values for the test write-request generator.
package test_wr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StReq
    } state_e;

    localparam int unsigned DefAddrW    = 25;
    localparam int unsigned DefCntW     = 16;
    localparam int unsigned DefTimeW    = 32;
    localparam int unsigned DefBurst    = 1024;
    localparam int unsigned DefTime     = 125000;
    localparam int unsigned DefAddrStep = 1;
    localparam int unsigned DefTimeout  = 256;

endpackage

// File: rtl/start_sync.sv
// Three-flop synchroniser for the asynchronous start request with rising-edge pulse.
module start_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic pulse_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], start_i};
        end
    end

    // Edge taken from the two oldest stages so the first stage can settle.
    assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/test_wr_burst.sv
// Periodic burst write-request generator with req/ack handshake toward the write path.
// Optional ack timeout is built when TEST_WR_ACK_TIMEOUT_EN is defined.
module test_wr_burst
    import test_wr_pkg::*;
#(
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned CNT_W     = DefCntW,
    parameter int unsigned TIME_W    = DefTimeW,
    parameter int unsigned BURST     = DefBurst,
    parameter int unsigned TIME      = DefTime,
    parameter int unsigned ADDR_STEP = DefAddrStep,
    parameter int unsigned TIMEOUT   = DefTimeout
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              continuous_i,
    input  logic              wr_ack_i,
    output logic              wr_req_o,
    output logic [ADDR_W-1:0] wr_adr_o,
    output logic [CNT_W-1:0]  wr_num_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovr_o
);

    localparam logic [CNT_W-1:0]  LastNum  = CNT_W'(BURST - 1);
    localparam logic [TIME_W-1:0] LastTick = TIME_W'(TIME - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [TIME_W-1:0]   timer_q, timer_d;
    logic                ovr_q, ovr_d;
    logic                done_q, done_d;
    logic                start_pulse;
    logic                boundary;
    logic                timeout;

    start_sync u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .pulse_o (start_pulse)
    );

    assign boundary = (timer_q == LastTick);

`ifdef TEST_WR_ACK_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT + 1);

    logic [ToW-1:0] to_q, to_d;

    assign timeout = (state_q == StReq) && !wr_ack_i && (to_q == ToW'(TIMEOUT - 1));

    always_comb begin
        to_d = '0;
        if (state_q == StReq && !wr_ack_i && !timeout) begin
            to_d = to_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        num_d   = num_q;
        timer_d = timer_q;
        ovr_d   = ovr_q;
        done_d  = 1'b0;

        if (state_q != StIdle) begin
            timer_d = boundary ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start_pulse) begin
                    if (BURST == 0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StWait;
                        adr_d   = '0;
                        num_d   = '0;
                        timer_d = '0;
                        ovr_d   = 1'b0;
                    end
                end
            end
            StWait: begin
                if (stop_i) begin
                    state_d = StIdle;
                end else if (boundary) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                // A boundary while still requesting loses that slot.
                if (boundary) begin
                    ovr_d = 1'b1;
                end
                if (wr_ack_i || timeout) begin
                    adr_d = adr_q + ADDR_W'(ADDR_STEP);
                    num_d = num_q + 1'b1;
                    if (timeout) begin
                        ovr_d = 1'b1;
                    end
                    if (stop_i) begin
                        state_d = StIdle;
                    end else if (num_q == LastNum) begin
                        if (continuous_i) begin
                            num_d   = '0;
                            state_d = StWait;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            adr_q   <= '0;
            num_q   <= '0;
            timer_q <= '0;
            ovr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            num_q   <= num_d;
            timer_q <= timer_d;
            ovr_q   <= ovr_d;
            done_q  <= done_d;
        end
    end

    assign wr_req_o = (state_q == StReq);
    assign busy_o   = (state_q != StIdle);
    assign done_o   = done_q;
    assign ovr_o    = ovr_q;
    assign wr_adr_o = adr_q;
    assign wr_num_o = num_q;

endmodule

// File: tb/tb_test_wr_burst.sv
// Randomised self-checking bench for test_wr_burst against a transaction-level model.
module tb_test_wr_burst;

    localparam int unsigned AW    = 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned TW    = 8;
    localparam int unsigned BURST = 4;
    localparam int unsigned TIME  = 10;
    localparam int unsigned STEP  = 4;
    localparam int unsigned TMO   = 5;
`ifdef TEST_WR_ACK_TIMEOUT_EN
    localparam int unsigned DMAX  = TMO - 2;
`else
    localparam int unsigned DMAX  = TIME - 2;
`endif

    logic          clk = 1'b0;
    logic          rst, start, stop, cont, ack;
    logic          wr_req, busy, done, ovr;
    logic [AW-1:0] wr_adr;
    logic [CW-1:0] wr_num;
    logic          z_req, z_busy, z_done, z_ovr;
    logic [AW-1:0] z_adr;
    logic [CW-1:0] z_num;

    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    // Transaction-level model state
    int unsigned w_cnt;
    int unsigned last_rise;
    int unsigned next_gap;
    logic        ovr_m;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    test_wr_burst #(
        .ADDR_W(AW), .CNT_W(CW), .TIME_W(TW), .BURST(BURST),
        .TIME(TIME), .ADDR_STEP(STEP), .TIMEOUT(TMO)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
        .continuous_i(cont), .wr_ack_i(ack), .wr_req_o(wr_req), .wr_adr_o(wr_adr),
        .wr_num_o(wr_num), .busy_o(busy), .done_o(done), .ovr_o(ovr)
    );

    test_wr_burst #(
        .ADDR_W(AW), .CNT_W(CW), .TIME_W(TW), .BURST(0),
        .TIME(TIME), .ADDR_STEP(STEP), .TIMEOUT(TMO)
    ) u_dut_zero (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
        .continuous_i(cont), .wr_ack_i(ack), .wr_req_o(z_req), .wr_adr_o(z_adr),
        .wr_num_o(z_num), .busy_o(z_busy), .done_o(z_done), .ovr_o(z_ovr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_adr(input int unsigned n);
        return 32'(AW'(n * STEP));
    endfunction

    task automatic do_start();
        start = 1'b1;
        tick();
        tick();
        check_eq("busy_pre", busy, 0);
        tick();
        check_eq("busy_start", busy, 1);
        check_eq("zero_done", z_done, 1);
        check_eq("zero_busy", z_busy, 0);
        start     = 1'b0;
        w_cnt     = 0;
        ovr_m     = 1'b0;
        last_rise = cyc;
        next_gap  = TIME;
        tick();
        check_eq("zero_done_end", z_done, 0);
        check_eq("zero_req", z_req, 0);
    endtask

    // Waits for wr_req, toggling ack randomly while no request is pending.
    task automatic wait_req(output int unsigned t);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (wr_req) begin
                ack  = 1'b0;
                seen = 1'b1;
                break;
            end
            ack = ($urandom_range(0, 3) == 0);
        end
        ack = 1'b0;
        check_eq("req_seen", 32'(seen), 1);
        t = cyc;
    endtask

    task automatic do_write(input int unsigned d, input bit use_stop);
        int unsigned r;
        wait_req(r);
        check_eq("req_gap", r - last_rise, next_gap);
        check_eq("adr", wr_adr, exp_adr(w_cnt));
        check_eq("num", wr_num, w_cnt % BURST);
        if (use_stop) stop = 1'b1;
        for (int i = 0; i < int'(d); i++) begin
            check_eq("req_hold", wr_req, 1);
            tick();
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        w_cnt++;
        if (d + 1 >= TIME) ovr_m = 1'b1;
        next_gap  = TIME * ((d + 1) / TIME + 1);
        last_rise = r;
        check_eq("req_drop", wr_req, 0);
        check_eq("adr_next", wr_adr, exp_adr(w_cnt));
        check_eq("ovr", ovr, ovr_m);
        if (use_stop) begin
            stop = 1'b0;
            check_eq("stop_busy", busy, 0);
            check_eq("stop_done", done, 0);
        end else if (w_cnt % BURST == 0 && !cont) begin
            check_eq("end_busy", busy, 0);
            check_eq("end_done", done, 1);
            tick();
            check_eq("done_pulse", done, 0);
        end else begin
            check_eq("mid_busy", busy, 1);
            check_eq("mid_done", done, 0);
            check_eq("num_next", wr_num, w_cnt % BURST);
        end
    endtask

    initial begin
        int unsigned r;
        rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; ack = 1'b0;
        tick();
        tick();
        check_eq("rst_req", wr_req, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ovr", ovr, 0);
        check_eq("rst_adr", wr_adr, 0);
        check_eq("rst_num", wr_num, 0);
        rst = 1'b0;
        repeat (3) tick();

        // Single-shot burst
        cont = 1'b0;
        do_start();
        for (int k = 0; k < int'(BURST); k++) do_write($urandom_range(0, DMAX), 1'b0);
        repeat (3) tick();

        // Continuous run, start pulsed while busy, stop during the last write of a burst
        cont = 1'b1;
        do_start();
        for (int k = 0; k < 7; k++) begin
            if (k == 2) start = 1'b1;
            if (k == 4) start = 1'b0;
            do_write($urandom_range(0, DMAX), 1'b0);
        end
        do_write($urandom_range(0, DMAX), 1'b1);
        repeat (3) tick();

        cont = 1'b1;
        do_start();
        do_write($urandom_range(0, DMAX), 1'b0);
`ifdef TEST_WR_ACK_TIMEOUT_EN
        // No ack: request must drop after TMO clocks and count as a completed write
        wait_req(r);
        check_eq("to_gap", r - last_rise, next_gap);
        for (int i = 0; i < int'(TMO); i++) begin
            check_eq("to_hold", wr_req, 1);
            tick();
        end
        check_eq("to_drop", wr_req, 0);
        w_cnt++;
        ovr_m     = 1'b1;
        last_rise = r;
        next_gap  = TIME;
        check_eq("to_adr", wr_adr, exp_adr(w_cnt));
        check_eq("to_ovr", ovr, 1);
`else
        // Late ack crosses a period boundary
        do_write(12, 1'b0);
`endif
        do_write($urandom_range(0, DMAX), 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("wstop_busy", busy, 0);
        check_eq("wstop_done", done, 0);
        check_eq("wstop_req", wr_req, 0);
        check_eq("wstop_ovr", ovr, 1);
        repeat (3) tick();

        // Asynchronous reset while a request is pending
        cont = 1'b1;
        do_start();
        do_write($urandom_range(0, DMAX), 1'b0);
        do_write($urandom_range(0, DMAX), 1'b0);
        wait_req(r);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_req", wr_req, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_adr", wr_adr, 0);
        check_eq("arst_num", wr_num, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Random rounds
        for (int round = 0; round < 4; round++) begin
            cont = 1'($urandom_range(0, 1));
            do_start();
            if (cont) begin
                for (int k = 0; k < int'(BURST) + 2; k++)
                    do_write($urandom_range(0, DMAX), k == int'(BURST) + 1);
            end else begin
                for (int k = 0; k < int'(BURST); k++) do_write($urandom_range(0, DMAX), 1'b0);
            end
            repeat (3) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
